// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller and its FIFO.
package uart_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    ACK     = 2'b10
  } state_t;

  // A FIFO entry is {parity_err, rx_byte}.
  localparam int ENTRY_W  = 9;
  localparam int PERR_BIT = 8;

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO holding received bytes with their parity flag.
module uart_rx_ctrl_fifo
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        cnt;
  logic [ENTRY_W-1:0] hold_q;
  logic               do_push;
  logic               do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);

  // Once drained, the last popped entry stays visible instead of stale storage.
  assign head_data = empty ? hold_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold_q <= mem[rd_ptr];
      end
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: strobe capture FSM, RX FIFO, sticky error flags and interrupts.
// Optional idle-timeout interrupt is built when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int RX_THRESH     = 8,
  parameter int TIMEOUT_TICKS = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   baud_clock,
  input  logic [7:0]             rx_byte,
  input  logic                   fifo_write,
  input  logic                   parity_err,
  input  logic                   framing_error,
  input  logic                   rx_idle,
  output logic                   read_rx_byte,
  output logic                   clear_parity,
  output logic                   clear_framing_error,
  input  logic                   host_rd,
  input  logic                   host_status_rd,
  output logic [7:0]             host_data,
  output logic                   host_perr,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   overrun,
  output logic                   frame_err,
  output logic                   irq_level,
  output logic                   irq_timeout
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] THRESH = CW'(RX_THRESH);

  state_t             state;
  state_t             state_nx;
  logic               strobe;
  logic               pending;
  logic [ENTRY_W-1:0] cap_q;
  logic               fe_q;
  logic               fe_rise;
  logic               fifo_push;
  logic               drop;
  logic [ENTRY_W-1:0] head;

  assign strobe    = ~fifo_write;
  assign fifo_push = (state == CAPTURE);
  assign fe_rise   = framing_error & ~fe_q;
  // host_rd on a full FIFO always pops, so the push then fits.
  assign drop      = fifo_push && fifo_full && !host_rd;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (strobe || pending) state_nx = CAPTURE;
      CAPTURE: state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state               <= IDLE;
      pending             <= 1'b0;
      read_rx_byte        <= 1'b0;
      clear_parity        <= 1'b0;
      clear_framing_error <= 1'b0;
      fe_q                <= 1'b0;
      overrun             <= 1'b0;
      frame_err           <= 1'b0;
    end else begin
      state <= state_nx;
      if (state != IDLE && strobe) pending <= 1'b1;
      else if (state == IDLE)      pending <= 1'b0;
      read_rx_byte        <= (state == ACK);
      clear_parity        <= (state == ACK);
      clear_framing_error <= fe_rise;
      fe_q                <= framing_error;
      if (drop)                overrun <= 1'b1;
      else if (host_status_rd) overrun <= 1'b0;
      if (fe_rise)             frame_err <= 1'b1;
      else if (host_status_rd) frame_err <= 1'b0;
    end
  end

  // Reloading during CAPTURE is safe: the push on that edge takes the old value.
  always_ff @(posedge clk) begin
    if (strobe) cap_q <= {parity_err, rx_byte};
  end

  uart_rx_ctrl_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (cap_q),
    .pop       (host_rd),
    .head_data (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (rx_count)
  );

  assign host_data = head[7:0];
  assign host_perr = head[PERR_BIT];
  assign irq_level = (rx_count >= THRESH);

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_TICKS);

  logic [7:0] to_cnt;
  logic       to_irq;
  logic       push_ok;
  logic       pop_ok;

  assign pop_ok      = host_rd && !fifo_empty;
  assign push_ok     = fifo_push && (!fifo_full || pop_ok);
  assign irq_timeout = to_irq;

  // Counter parks at the limit so the interrupt holds until FIFO activity.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt <= '0;
      to_irq <= 1'b0;
    end else if (push_ok || pop_ok) begin
      to_cnt <= '0;
      to_irq <= 1'b0;
    end else if (baud_clock && rx_idle && !fifo_empty && to_cnt != TO_LIMIT) begin
      to_cnt <= to_cnt + 8'd1;
      if (to_cnt + 8'd1 == TO_LIMIT) to_irq <= 1'b1;
    end
  end
`else
  logic unused_timeout_inputs;
  assign unused_timeout_inputs = &{1'b0, baud_clock, rx_idle};
  assign irq_timeout = 1'b0;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16: RX FIFO entries, power of two, 2..256.
REQ-002 SHALL have parameter RX_THRESH, default 8: fill level that asserts irq_level, 1..DEPTH.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 32: baud_clock pulses of idle before timeout, 1..255.
REQ-004 SHALL have port clk, input, 1: system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port baud_clock, input, 1: 8x baud enable pulse, one clk wide.
REQ-007 SHALL have ports rx_byte (input, 8), fifo_write (input, 1, active-low one-cycle strobe), parity_err (input, 1), framing_error (input, 1), rx_idle (input, 1), all from the receiver.
REQ-008 SHALL have outputs read_rx_byte, clear_parity and clear_framing_error, 1 each, driven to the receiver.
REQ-009 SHALL have inputs host_rd (1, pop) and host_status_rd (1, clear sticky flags).
REQ-010 SHALL have outputs host_data (8), host_perr (1), fifo_empty (1), fifo_full (1), rx_count ($clog2(DEPTH)+1), overrun (1), frame_err (1), irq_level (1) and irq_timeout (1).

Function
REQ-011 SHALL run an FSM with states IDLE, CAPTURE and ACK; any illegal encoding SHALL return to IDLE.
REQ-012 IDLE->CAPTURE when fifo_write==0; the cycle that sees the strobe SHALL register rx_byte and parity_err.
REQ-013 CAPTURE SHALL push {parity_err,rx_byte} if not full, or drop it and set overrun if full, then go to ACK; push-to-fifo_empty-low latency is exactly 1 clk after the strobe cycle.
REQ-014 ACK SHALL pulse read_rx_byte and clear_parity high for exactly one clk, then go to IDLE.
REQ-015 A fifo_write strobe arriving in CAPTURE or ACK SHALL be held pending and serviced on the following IDLE cycle; no byte is lost when strobes are at least 3 clks apart.
REQ-016 The FIFO SHALL be first-word-fall-through: host_data and host_perr always show the head entry; host_rd with !fifo_empty advances the head on the next clk.
REQ-017 host_rd while empty SHALL be ignored; host_data holds its value and no pointer changes.
REQ-018 A simultaneous push and pop SHALL both occur; when full, the pop frees space and the push is accepted, so overrun stays unchanged.
REQ-019 Pointers SHALL wrap modulo DEPTH; rx_count SHALL range 0..DEPTH; fifo_full SHALL equal (rx_count==DEPTH).
REQ-020 A rising edge of framing_error SHALL set sticky frame_err and pulse clear_framing_error for one clk.
REQ-021 overrun and frame_err SHALL clear on host_status_rd; a set in the same clk wins.
REQ-022 irq_level SHALL be combinational (rx_count >= RX_THRESH).

Reset
REQ-023 With reset_n==0 at a clk edge, the FSM SHALL go to IDLE and pointers, rx_count, pending strobe, sticky flags, timeout counter and all outputs SHALL go to 0, with fifo_empty=1.
REQ-024 Reset mid-frame or mid-ACK SHALL abort without emitting a read_rx_byte pulse; FIFO contents are discarded.

Configuration
REQ-025 With UART_RX_CTRL_TIMEOUT_EN defined, an 8-bit counter SHALL increment on baud_clock while rx_idle==1, !fifo_empty and no push/pop occurs; it SHALL reset to 0 on any push or pop; when it reaches TIMEOUT_TICKS, irq_timeout SHALL be set and stay set until the next pop or push.
REQ-026 Without UART_RX_CTRL_TIMEOUT_EN, irq_timeout SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-027 Package uart_rx_ctrl_pkg SHALL hold the FSM state typedef, ENTRY_W=9 and the PERR_BIT=8 position constant.
REQ-028 Storage and pointers SHALL be sub-module uart_rx_ctrl_fifo (synchronous FWFT FIFO, DEPTH parameter); the FSM, flags and timeout stay in uart_rx_ctrl.

Verification
REQ-029 Strobe with rx_byte=8'hA5 and parity_err=0 -> next clk fifo_empty=0, host_data=A5, host_perr=0; read_rx_byte and clear_parity each pulse exactly once, 2 clks after the strobe.
REQ-030 17 strobes with DEPTH=16 and no host_rd -> fifo_full=1, rx_count=16, overrun=1; host_status_rd -> overrun=0; pop 16 entries -> order preserved, fifo_empty=1.
REQ-031 FIFO full while host_rd and a CAPTURE push land in the same clk -> rx_count stays 16 and overrun stays 0.
REQ-032 Strobe with parity_err=1, then a framing_error rising edge -> host_perr=1, frame_err=1, and clear_framing_error pulses once.
REQ-033 (TIMEOUT_EN) One byte queued, rx_idle=1, 32 baud_clock pulses -> irq_timeout=1; host_rd -> irq_timeout=0; without the macro, irq_timeout stays 0.
REQ-034 reset_n low for 1 clk during ACK -> no read_rx_byte pulse, rx_count=0, all flags 0.
